// File: rtl/colour_vote_filter_if.sv
// Detector-to-filter bundle: per-frame detection flags in, voted colour and vote counts out.
interface colour_vote_filter_if #(
  parameter int CNT_W = 4
);
  logic             sample_valid;
  logic             red_detected;
  logic             green_detected;
  logic             blue_detected;
  logic [1:0]       colour_code;
  logic             colour_valid;
  logic             colour_changed;
  logic [CNT_W-1:0] red_votes;
  logic [CNT_W-1:0] green_votes;
  logic [CNT_W-1:0] blue_votes;
  logic             busy;

  modport master (
    output sample_valid, red_detected, green_detected, blue_detected,
    input  colour_code, colour_valid, colour_changed,
    input  red_votes, green_votes, blue_votes, busy
  );

  modport slave (
    input  sample_valid, red_detected, green_detected, blue_detected,
    output colour_code, colour_valid, colour_changed,
    output red_votes, green_votes, blue_votes, busy
  );
endinterface

// File: rtl/colour_vote_filter.sv
// Majority-vote temporal filter: counts single-colour detections over WINDOW frames
// and issues a stable colour code once per window.
module colour_vote_filter #(
  parameter int WINDOW    = 8,
  parameter int MIN_VOTES = 6,
  parameter int CNT_W     = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  colour_vote_filter_if.slave  vote_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_VOTES);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_red_cnt;
  logic [CNT_W-1:0] r_green_cnt;
  logic [CNT_W-1:0] r_blue_cnt;
  logic [1:0]       r_colour_code;
  logic             r_colour_valid;
  logic             r_colour_changed;
  logic [CNT_W-1:0] r_red_votes;
  logic [CNT_W-1:0] r_green_votes;
  logic [CNT_W-1:0] r_blue_votes;
  logic             w_red_inc;
  logic             w_green_inc;
  logic             w_blue_inc;
  logic [1:0]       w_code;

  // Only a frame with exactly one flag set votes for a colour.
  assign w_red_inc   = vote_bus.sample_valid &  vote_bus.red_detected & ~vote_bus.green_detected & ~vote_bus.blue_detected;
  assign w_green_inc = vote_bus.sample_valid & ~vote_bus.red_detected &  vote_bus.green_detected & ~vote_bus.blue_detected;
  assign w_blue_inc  = vote_bus.sample_valid & ~vote_bus.red_detected & ~vote_bus.green_detected &  vote_bus.blue_detected;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (vote_bus.sample_valid) w_state_next = ACCUM;
      ACCUM:   if (vote_bus.sample_valid && (r_sample_cnt == LAST_IDX)) w_state_next = DECIDE;
      DECIDE:  w_state_next = vote_bus.sample_valid ? ACCUM : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_code = 2'd0;
    if (r_red_cnt >= MIN_CNT)        w_code = 2'd1;
    else if (r_green_cnt >= MIN_CNT) w_code = 2'd2;
    else if (r_blue_cnt >= MIN_CNT)  w_code = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_sample_cnt     <= '0;
      r_red_cnt        <= '0;
      r_green_cnt      <= '0;
      r_blue_cnt       <= '0;
      r_colour_code    <= 2'd0;
      r_colour_valid   <= 1'b0;
      r_colour_changed <= 1'b0;
      r_red_votes      <= '0;
      r_green_votes    <= '0;
      r_blue_votes     <= '0;
    end else begin
      r_state          <= w_state_next;
      r_colour_valid   <= 1'b0;
      r_colour_changed <= 1'b0;
      if (r_state == DECIDE) begin
        r_colour_code    <= w_code;
        r_colour_valid   <= 1'b1;
        r_colour_changed <= (w_code != r_colour_code);
        r_red_votes      <= r_red_cnt;
        r_green_votes    <= r_green_cnt;
        r_blue_votes     <= r_blue_cnt;
        // A sample arriving during DECIDE opens the next window.
        r_sample_cnt     <= CNT_W'(vote_bus.sample_valid);
        r_red_cnt        <= CNT_W'(w_red_inc);
        r_green_cnt      <= CNT_W'(w_green_inc);
        r_blue_cnt       <= CNT_W'(w_blue_inc);
      end else begin
        r_sample_cnt     <= r_sample_cnt + CNT_W'(vote_bus.sample_valid);
        r_red_cnt        <= r_red_cnt + CNT_W'(w_red_inc);
        r_green_cnt      <= r_green_cnt + CNT_W'(w_green_inc);
        r_blue_cnt       <= r_blue_cnt + CNT_W'(w_blue_inc);
      end
    end
  end

  assign vote_bus.colour_code    = r_colour_code;
  assign vote_bus.colour_valid   = r_colour_valid;
  assign vote_bus.colour_changed = r_colour_changed;
  assign vote_bus.red_votes      = r_red_votes;
  assign vote_bus.green_votes    = r_green_votes;
  assign vote_bus.blue_votes     = r_blue_votes;
  assign vote_bus.busy           = (r_state == ACCUM);

endmodule

// File: tb/tb_colour_vote_filter.sv
// Directed plus randomized bench for colour_vote_filter against a frame-counting vote model.
module tb_colour_vote_filter;

  localparam int WINDOW    = 8;
  localparam int MIN_VOTES = 6;
  localparam int CNT_W     = 4;

  typedef struct {
    int code;
    int changed;
    int rv;
    int gv;
    int bv;
  } decision_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   n_dec;
  logic prev_valid;
  logic started;

  decision_t exp_q[$];
  int        valid_cyc[$];
  int        m_r, m_g, m_b, m_n, m_prev;
  decision_t m_last;

  colour_vote_filter_if #(.CNT_W(CNT_W)) bus ();

  colour_vote_filter #(
    .WINDOW(WINDOW),
    .MIN_VOTES(MIN_VOTES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vote_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_g = 0; m_b = 0; m_n = 0; m_prev = 0;
    m_last = '{0, 0, 0, 0, 0};
    exp_q.delete();
  endtask

  // A window of WINDOW samples yields one decision; frames with !=1 flag vote for nobody.
  task automatic model_sample(input logic r, input logic g, input logic b);
    decision_t d;
    if (int'(r) + int'(g) + int'(b) == 1) begin
      m_r += int'(r); m_g += int'(g); m_b += int'(b);
    end
    m_n++;
    if (m_n == WINDOW) begin
      d.rv = m_r; d.gv = m_g; d.bv = m_b;
      if (m_r >= MIN_VOTES)      d.code = 1;
      else if (m_g >= MIN_VOTES) d.code = 2;
      else if (m_b >= MIN_VOTES) d.code = 3;
      else                       d.code = 0;
      d.changed = (d.code != m_prev) ? 1 : 0;
      m_prev = d.code;
      m_last = d;
      exp_q.push_back(d);
      m_r = 0; m_g = 0; m_b = 0; m_n = 0;
    end
  endtask

  // Each call occupies exactly one clock cycle (driven at negedge).
  task automatic drive(input logic v, input logic r, input logic g, input logic b);
    bus.sample_valid   = v;
    bus.red_detected   = r;
    bus.green_detected = g;
    bus.blue_detected  = b;
    if (v && rst_n) model_sample(r, g, b);
    @(negedge clk);
  endtask

  task automatic send(input logic r, input logic g, input logic b, input int gap);
    drive(1'b1, r, g, b);
    repeat (gap) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic settle_and_check(input string tag);
    repeat (6) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_code_hold"}, bus.colour_code, m_last.code);
    chk({tag, "_red_hold"}, bus.red_votes, m_last.rv);
    chk({tag, "_green_hold"}, bus.green_votes, m_last.gv);
    chk({tag, "_blue_hold"}, bus.blue_votes, m_last.bv);
    $display("step %s: decisions=%0d code=%0d r=%0d g=%0d b=%0d", tag, n_dec,
             bus.colour_code, bus.red_votes, bus.green_votes, bus.blue_votes);
  endtask

  always @(negedge clk) begin
    decision_t e;
    if (!rst_n || !started) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= bus.colour_valid;
      if (bus.colour_valid) begin
        n_dec <= n_dec + 1;
        valid_cyc.push_back(cyc);
        chk("valid_pulse_single", prev_valid, 0);
        chk("decision_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("code", bus.colour_code, e.code);
          chk("changed", bus.colour_changed, e.changed);
          chk("red_votes", bus.red_votes, e.rv);
          chk("green_votes", bus.green_votes, e.gv);
          chk("blue_votes", bus.blue_votes, e.bv);
          $display("decision @%0d code=%0d chg=%0d r=%0d g=%0d b=%0d", cyc,
                   bus.colour_code, bus.colour_changed, bus.red_votes, bus.green_votes, bus.blue_votes);
        end
      end else begin
        chk("changed_without_valid", bus.colour_changed, 0);
      end
    end
  end

  initial begin
    int d0;
    int c;
    n_checks = 0; n_fail = 0; cyc = 0; n_dec = 0; started = 1'b0;
    model_reset();
    rst_n = 1'b0;
    bus.sample_valid = 1'b0; bus.red_detected = 1'b0;
    bus.green_detected = 1'b0; bus.blue_detected = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // 1: reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_code", bus.colour_code, 0);
      chk("rst_valid", bus.colour_valid, 0);
      chk("rst_changed", bus.colour_changed, 0);
      chk("rst_votes", {bus.red_votes, bus.green_votes, bus.blue_votes}, 0);
      chk("rst_busy", bus.busy, 0);
    end
    rst_n = 1'b1;
    started = 1'b1;
    settle_and_check("t1_idle");
    chk("t1_no_decision", n_dec, 0);

    // 2: red window, 3-cycle spacing
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0, 1'b0, 2);
      if (i == 3) chk("t2_busy_mid", bus.busy, 1);
    end
    settle_and_check("t2_red");
    chk("t2_code", bus.colour_code, 1);

    // 3: split 5 green + 3 blue
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b1, 1);
    settle_and_check("t3_split");

    // 4: ambiguous red+green
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 1'b0, 1);
    settle_and_check("t4_ambig");

    // 5: back-to-back blue, 16 consecutive strobes
    d0 = n_dec;
    valid_cyc.delete();
    for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 1'b1, 0);
    settle_and_check("t5_b2b");
    chk("t5_decisions", n_dec - d0, 2);
    if (valid_cyc.size() == 2) chk("t5_spacing", valid_cyc[1] - valid_cyc[0], 8);
    else chk("t5_spacing_count", valid_cyc.size(), 2);

    // 6: reset mid-window discards partial votes
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b0, 0);
    chk("t6_busy_partial", bus.busy, 1);
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("t6_rst_code", bus.colour_code, 0);
    d0 = n_dec;
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 1'b0, 1);
    settle_and_check("t6_after_rst");
    chk("t6_decisions", n_dec - d0, 1);

    // Random windows biased toward a dominant colour so the threshold boundary is exercised.
    for (int w = 0; w < 12; w++) begin
      c = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) begin
        logic [2:0] f;
        if ($urandom_range(0, 99) < 75) f = 3'b100 >> c;
        else f = 3'($urandom);
        send(f[2], f[1], f[0], $urandom_range(0, 2));
      end
    end
    settle_and_check("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
